// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - recovers MM:SS from multiplexed common-anode 7-segment scan lines
module seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       AN0,
  input  logic       AN1,
  input  logic       AN2,
  input  logic       AN3,
  input  logic       CA,
  input  logic       CB,
  input  logic       CC,
  input  logic       CD,
  input  logic       CE,
  input  logic       CF,
  input  logic       CG,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [3:0] blank_mask,
  output logic       frame_done,
  output logic       seg_err,
  output logic       stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  // Synchronizers reset to all-ones: anodes off, segments dark (idle bus).
  logic [10:0] sync1, sync2;
  logic [3:0]  an;
  logic [6:0]  seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {AN3, AN2, AN1, AN0, CA, CB, CC, CD, CE, CF, CG};
      sync2 <= sync1;
    end
  end

  assign an  = sync2[10:7];
  assign seg = sync2[6:0];

  logic       active, idle, invalid;
  logic [1:0] idx;

  always_comb begin
    active  = 1'b0;
    idle    = 1'b0;
    invalid = 1'b0;
    idx     = 2'd0;
    case (an)
      4'b1110: begin active = 1'b1; idx = 2'd0; end
      4'b1101: begin active = 1'b1; idx = 2'd1; end
      4'b1011: begin active = 1'b1; idx = 2'd2; end
      4'b0111: begin active = 1'b1; idx = 2'd3; end
      4'b1111: idle = 1'b1;
      default: invalid = 1'b1;
    endcase
  end

  logic [3:0] dig;
  logic       legal, blank;

  always_comb begin
    dig   = 4'd0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      7'b0000001: dig = 4'd0;
      7'b1001111: dig = 4'd1;
      7'b0010010: dig = 4'd2;
      7'b0000110: dig = 4'd3;
      7'b1001100: dig = 4'd4;
      7'b0100100: dig = 4'd5;
      7'b0100000: dig = 4'd6;
      7'b0001111: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0000100: dig = 4'd9;
      7'b1111111: begin blank = 1'b1; legal = 1'b0; end
      default:    legal = 1'b0;
    endcase
  end

  logic            prev_active;
  logic [1:0]      prev_idx;
  logic [6:0]      prev_seg;
  logic [CW-1:0]   cnt, cnt_next;
  logic            done;
  logic [1:0]      done_idx;
  logic            invalid_q;
  logic            same, capture, commit;
  logic [3:0][3:0] sh_val;
  logic [3:0]      sh_blank;
  logic [3:0]      seen;
  logic [TW-1:0]   tcnt;

  assign same = active && prev_active && (idx == prev_idx) && (seg == prev_seg);

  always_comb begin
    cnt_next = '0;
    if (active) begin
      if (!same)                  cnt_next = CW'(1);
      else if (cnt == STABLE_MAX) cnt_next = cnt;
      else                        cnt_next = cnt + CW'(1);
    end
  end

  // A digit is taken once per activation; a segment change under the same anode does not re-arm.
  assign capture = (cnt_next == STABLE_MAX) && (cnt != STABLE_MAX) &&
                   !(done && (done_idx == idx));
  assign commit  = &seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_active <= 1'b0;
      prev_idx    <= 2'd0;
      prev_seg    <= '1;
      cnt         <= '0;
      done        <= 1'b0;
      done_idx    <= 2'd0;
      invalid_q   <= 1'b0;
      sh_val      <= '0;
      sh_blank    <= '0;
      seen        <= '0;
      tcnt        <= '0;
      minutes     <= 8'h00;
      seconds     <= 8'h00;
      blank_mask  <= 4'b0000;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
      stale       <= 1'b1;
    end else begin
      prev_active <= active;
      prev_idx    <= idx;
      prev_seg    <= seg;
      cnt         <= cnt_next;
      invalid_q   <= invalid;

      if (capture) begin
        done     <= 1'b1;
        done_idx <= idx;
      end else if (idle) begin
        done <= 1'b0;
      end

      if (capture && legal) begin
        sh_val[idx]   <= dig;
        sh_blank[idx] <= 1'b0;
      end else if (capture && blank) begin
        sh_blank[idx] <= 1'b1;
      end

      seen <= (commit ? 4'b0000 : seen) | (capture ? (4'b0001 << idx) : 4'b0000);

      seg_err    <= (invalid && !invalid_q) || (capture && !legal && !blank);
      frame_done <= commit;
      if (commit) begin
        minutes    <= {sh_val[3], sh_val[2]};
        seconds    <= {sh_val[1], sh_val[0]};
        blank_mask <= sh_blank;
      end

      if (capture)                 tcnt <= '0;
      else if (tcnt != TIMEOUT_MAX) tcnt <= tcnt + TW'(1);

      if (commit)
        stale <= 1'b0;
      else if (!capture && (tcnt == TIMEOUT_MAX - TW'(1)))
        stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed self-checking bench for seg_capture
module tb_seg_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an  = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic [7:0] minutes, seconds;
  logic [3:0] blank_mask;
  logic       frame_done, seg_err, stale;

  int total = 0;
  int bad   = 0;
  int cyc    = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  int fd_cyc = 0;
  int last_start = 0;

  seg_capture #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .AN0(an[0]), .AN1(an[1]), .AN2(an[2]), .AN3(an[3]),
    .CA(seg[6]), .CB(seg[5]), .CC(seg[4]), .CD(seg[3]),
    .CE(seg[2]), .CF(seg[1]), .CG(seg[0]),
    .minutes(minutes), .seconds(seconds), .blank_mask(blank_mask),
    .frame_done(frame_done), .seg_err(seg_err), .stale(stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (frame_done) begin fd_cnt = fd_cnt + 1; fd_cyc = cyc; end
    if (seg_err) se_cnt = se_cnt + 1;
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'h01; 1: pat = 7'h4F; 2: pat = 7'h12; 3: pat = 7'h06; 4: pat = 7'h4C;
      5: pat = 7'h24; 6: pat = 7'h20; 7: pat = 7'h0F; 8: pat = 7'h00; 9: pat = 7'h04;
      default: pat = 7'h7F;
    endcase
  endfunction

  task automatic scan_digit(input int idx, input logic [6:0] s, input int glen, input logic [6:0] gs);
    @(posedge clk); #1;
    an = ~(4'b0001 << idx);
    last_start = cyc;
    for (int i = 0; i < 64; i++) begin
      seg = (i < glen) ? gs : s;
      @(posedge clk); #1;
    end
    an = 4'hF; seg = 7'h7F;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (minutes !== 8'h00) begin bad++; $display("FAIL reset_minutes got=%h want=00", minutes); end
    total++; if (seconds !== 8'h00) begin bad++; $display("FAIL reset_seconds got=%h want=00", seconds); end
    total++; if (blank_mask !== 4'b0000) begin bad++; $display("FAIL reset_blank got=%b want=0000", blank_mask); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (seg_err !== 1'b0) begin bad++; $display("FAIL reset_seg_err got=%b want=0", seg_err); end
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL reset_stale got=%b want=1", stale); end
  endtask

  task automatic test_clean;
    int fd0, se0;
    fd0 = fd_cnt; se0 = se_cnt;
    scan_digit(3, pat(1), 0, 7'h7F);
    scan_digit(2, pat(2), 0, 7'h7F);
    scan_digit(1, pat(3), 0, 7'h7F);
    total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL clean_early_frame got=%0d want=0", fd_cnt - fd0); end
    scan_digit(0, pat(4), 0, 7'h7F);
    @(negedge clk);
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL clean_frames got=%0d want=1", fd_cnt - fd0); end
    total++; if (fd_cyc - last_start !== 19) begin bad++; $display("FAIL clean_latency got=%0d want=19", fd_cyc - last_start); end
    total++; if (minutes !== 8'h12) begin bad++; $display("FAIL clean_minutes got=%h want=12", minutes); end
    total++; if (seconds !== 8'h34) begin bad++; $display("FAIL clean_seconds got=%h want=34", seconds); end
    total++; if (blank_mask !== 4'b0000) begin bad++; $display("FAIL clean_blank got=%b want=0000", blank_mask); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL clean_stale got=%b want=0", stale); end
    total++; if (se_cnt - se0 !== 0) begin bad++; $display("FAIL clean_seg_err got=%0d want=0", se_cnt - se0); end
  endtask

  task automatic test_glitch;
    int fd0, se0;
    fd0 = fd_cnt; se0 = se_cnt;
    scan_digit(3, pat(5), 5, pat(8));
    scan_digit(2, pat(6), 5, pat(8));
    scan_digit(1, pat(7), 5, pat(8));
    scan_digit(0, pat(8), 5, pat(0));
    @(negedge clk);
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL glitch_frames got=%0d want=1", fd_cnt - fd0); end
    total++; if (minutes !== 8'h56) begin bad++; $display("FAIL glitch_minutes got=%h want=56", minutes); end
    total++; if (seconds !== 8'h78) begin bad++; $display("FAIL glitch_seconds got=%h want=78", seconds); end
    total++; if (se_cnt - se0 !== 0) begin bad++; $display("FAIL glitch_seg_err got=%0d want=0", se_cnt - se0); end
  endtask

  task automatic test_blank;
    scan_digit(3, 7'h7F, 0, 7'h7F);
    scan_digit(2, 7'h7F, 0, 7'h7F);
    scan_digit(1, pat(5), 0, 7'h7F);
    scan_digit(0, pat(9), 0, 7'h7F);
    @(negedge clk);
    total++; if (blank_mask !== 4'b1100) begin bad++; $display("FAIL blank_mask got=%b want=1100", blank_mask); end
    total++; if (minutes !== 8'h56) begin bad++; $display("FAIL blank_minutes got=%h want=56", minutes); end
    total++; if (seconds !== 8'h59) begin bad++; $display("FAIL blank_seconds got=%h want=59", seconds); end
  endtask

  task automatic test_multi_anode;
    int fd0, se0;
    fd0 = fd_cnt; se0 = se_cnt;
    @(posedge clk); #1;
    an = 4'b1100; seg = pat(1);
    repeat (20) @(posedge clk);
    #1 an = 4'hF; seg = 7'h7F;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++; if (se_cnt - se0 !== 1) begin bad++; $display("FAIL multi_seg_err got=%0d want=1", se_cnt - se0); end
    scan_digit(3, pat(2), 0, 7'h7F);
    scan_digit(2, pat(3), 0, 7'h7F);
    scan_digit(1, pat(4), 0, 7'h7F);
    total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL multi_no_capture got=%0d want=0", fd_cnt - fd0); end
    scan_digit(0, pat(5), 0, 7'h7F);
    @(negedge clk);
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL multi_frames got=%0d want=1", fd_cnt - fd0); end
    total++; if ({minutes, seconds} !== 16'h2345) begin bad++; $display("FAIL multi_time got=%h want=2345", {minutes, seconds}); end
    total++; if (blank_mask !== 4'b0000) begin bad++; $display("FAIL multi_blank got=%b want=0000", blank_mask); end
  endtask

  task automatic test_illegal_timeout;
    int fd0, se0;
    fd0 = fd_cnt; se0 = se_cnt;
    scan_digit(3, pat(0), 0, 7'h7F);
    scan_digit(2, pat(9), 0, 7'h7F);
    scan_digit(1, pat(1), 0, 7'h7F);
    scan_digit(0, 7'h70, 0, 7'h7F);
    @(negedge clk);
    total++; if (se_cnt - se0 !== 1) begin bad++; $display("FAIL illegal_seg_err got=%0d want=1", se_cnt - se0); end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL illegal_frames got=%0d want=1", fd_cnt - fd0); end
    total++; if ({minutes, seconds} !== 16'h0915) begin bad++; $display("FAIL illegal_time got=%h want=0915", {minutes, seconds}); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL illegal_stale got=%b want=0", stale); end
    repeat (600) @(posedge clk);
    @(negedge clk);
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL timeout_stale got=%b want=1", stale); end
    scan_digit(3, pat(0), 0, 7'h7F);
    scan_digit(2, pat(1), 0, 7'h7F);
    scan_digit(1, pat(0), 0, 7'h7F);
    scan_digit(0, pat(2), 0, 7'h7F);
    @(negedge clk);
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL recover_stale got=%b want=0", stale); end
    total++; if ({minutes, seconds} !== 16'h0102) begin bad++; $display("FAIL recover_time got=%h want=0102", {minutes, seconds}); end
  endtask

  task automatic test_reset_midframe;
    int fd0;
    scan_digit(3, pat(4), 0, 7'h7F);
    scan_digit(2, pat(2), 0, 7'h7F);
    scan_digit(1, pat(3), 0, 7'h7F);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    total++; if ({minutes, seconds} !== 16'h0000) begin bad++; $display("FAIL midrst_time got=%h want=0000", {minutes, seconds}); end
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL midrst_stale got=%b want=1", stale); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fd0 = fd_cnt;
    scan_digit(3, pat(7), 0, 7'h7F);
    scan_digit(2, pat(6), 0, 7'h7F);
    scan_digit(1, pat(5), 0, 7'h7F);
    @(negedge clk);
    total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL midrst_early got=%0d want=0", fd_cnt - fd0); end
    scan_digit(0, pat(4), 0, 7'h7F);
    @(negedge clk);
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL midrst_frames got=%0d want=1", fd_cnt - fd0); end
    total++; if ({minutes, seconds} !== 16'h7654) begin bad++; $display("FAIL midrst_time2 got=%h want=7654", {minutes, seconds}); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_glitch;
    test_blank;
    test_multi_anode;
    test_illegal_timeout;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
